vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-timing master for a 640x480 @ 60 Hz VGA output.
//   Divides clk down to a one-cycle pixel enable, runs the horizontal and
//   vertical counters, and drives registered, pixel-aligned sync and colour pins.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   rgb_in[11:0]     colour from the pixel generator for the current hCount/vCount
//   test_sel         selects the built-in colour-bar pattern (VGA_TEST_PATTERN_EN builds only)
//   hCount, vCount   current column / line (10-bit)
//   bright           current pixel is visible (combinational from the counters)
//   pix_en           one-clk pulse per pixel period
//   frame_tick       one-clk pulse after the pixel enable that wraps the frame
//   hSync, vSync     active-low sync pins, registered
//   vga_r/g/b        4-bit colour pins, registered
//
// Optional feature: define VGA_TEST_PATTERN_EN to add the eight-bar test pattern.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_DISP_START = 144,
  parameter int unsigned H_DISP_END   = 783,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_DISP_START = 35,
  parameter int unsigned V_DISP_END   = 514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  input  logic        test_sel,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned BAR_PX = 80;

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic             h_last;
  logic             v_last;
  logic [11:0]      pix_rgb;

  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_last   = (hCount == CNT_W'(H_TOTAL - 1));
  assign v_last   = (vCount == CNT_W'(V_TOTAL - 1));

  // Visible-window decode, seen by the colour generator in the same cycle as the counters
  assign bright = (hCount >= CNT_W'(H_DISP_START)) && (hCount <= CNT_W'(H_DISP_END)) &&
                  (vCount >= CNT_W'(V_DISP_START)) && (vCount <= CNT_W'(V_DISP_END));

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  bar;
  logic [11:0] bar_rgb;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black:
  // red is off for bars 2,3,6,7, green for 4..7, blue for odd bars.
  always_comb begin
    bar     = 3'((hCount - CNT_W'(H_DISP_START)) / CNT_W'(BAR_PX));
    bar_rgb = {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}};
    pix_rgb = test_sel ? bar_rgb : rgb_in;
  end
`else
  logic unused_test_sel;

  assign unused_test_sel = test_sel;
  assign pix_rgb         = rgb_in;
`endif

  // Divider, counters and pin registers. pix_en is registered from the divider
  // phase so it is low throughout reset and first fires CLK_DIV clocks after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      pix_en     <= 1'b0;
      hCount     <= '0;
      vCount     <= '0;
      frame_tick <= 1'b0;
      hSync      <= 1'b1;
      vSync      <= 1'b1;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
    end else begin
      frame_tick <= 1'b0;
      pix_en     <= div_last;
      div_cnt    <= div_last ? '0 : div_cnt + 1'b1;

      if (pix_en) begin
        frame_tick <= h_last && v_last;
        if (h_last) begin
          hCount <= '0;
          vCount <= v_last ? '0 : vCount + 1'b1;
        end else begin
          hCount <= hCount + 1'b1;
        end
        // Sync and colour are captured together so they stay pixel-aligned
        hSync                 <= ~(hCount < CNT_W'(H_SYNC));
        vSync                 <= ~(vCount < CNT_W'(V_SYNC));
        {vga_r, vga_g, vga_b} <= bright ? pix_rgb : 12'h000;
      end
    end
  end

endmodule
